// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction memory byte write port out
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LAU        = 8
);
  logic                  rx_valid;
  logic [LAU-1:0]        rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LAU-1:0]        mem_data;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed boot image loader, holds the core in reset until a verified image is written
module imem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int LAU        = 8,
  parameter int SIZE_LAU   = 2**20
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  imem_loader_if.master bus,
  output logic         core_rst_no,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR
  } state_e;

  localparam logic [LAU-1:0]      SYNC   = LAU'(8'hA5);
  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH+1)'(SIZE_LAU);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [LAU-1:0]        sum_q, sum_d;
  logic [1:0]            idx_q, idx_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LAU-1:0]        mem_data_q, mem_data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  rx_ready;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] base_shift;
  logic [ADDR_WIDTH-1:0] len_shift;
  logic [ADDR_WIDTH:0]   end_w;

  // Multi-byte fields arrive LSB first, so each byte shifts in from the top.
  assign base_shift = {bus.rx_data, base_q[ADDR_WIDTH-1:LAU]};
  assign len_shift  = {bus.rx_data, len_q[ADDR_WIDTH-1:LAU]};
  assign end_w      = {1'b0, base_q} + {1'b0, len_shift};
  assign xfer       = bus.rx_valid && rx_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = done_q;
    error_d    = error_q;
    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == SYNC) begin
            state_d = S_ADDR;
            idx_d   = 2'd0;
          end
        end
        S_ADDR: begin
          base_d = base_shift;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_LEN;
        end
        S_LEN: begin
          len_d = len_shift;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Range check is one bit wider than the address so a wrapping BASE+LEN is rejected.
            if (end_w > SIZE_W) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else if (len_shift == '0) begin
              state_d = S_CHECK;
              sum_d   = '0;
            end else begin
              state_d = S_PAYLOAD;
              count_d = '0;
              sum_d   = '0;
            end
          end
        end
        S_PAYLOAD: begin
          mem_we_d   = 1'b1;
          mem_addr_d = base_q + count_q;
          mem_data_d = bus.rx_data;
          count_d    = count_q + 1'b1;
          sum_d      = sum_q + bus.rx_data;
          if (count_q == len_q - 1'b1) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (bus.rx_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rx_ready = 1'b0;
    busy_o   = 1'b0;
    case (state_q)
      S_IDLE:                    rx_ready = rst_ni;
      S_ADDR, S_LEN,
      S_PAYLOAD, S_CHECK: begin
        rx_ready = rst_ni;
        busy_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rx_ready = rx_ready;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign core_rst_no  = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  logic clk;
  logic rst_n;
  logic core_rst_n, busy, done, error;

  imem_loader_if #(.ADDR_WIDTH(32), .LAU(8)) bus ();

  imem_loader #(.ADDR_WIDTH(32), .LAU(8), .SIZE_LAU(2**20)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus.master),
    .core_rst_no (core_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int writes = 0;
  int run = 0;
  int max_run = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  pl[0:255];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      logic [39:0] e;
      writes++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {32'h0, bus.mem_addr}, {32'h0, e[39:8]});
        check("wr_data", {56'h0, bus.mem_data}, {56'h0, e[7:0]});
      end
    end else begin
      run = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("ready_timeout", 0, 1);
    if (gap) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'hEE;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_hdr(input logic [31:0] base, input logic [31:0] len, input bit gap);
    logic [31:0] v;
    send_byte(8'hA5, gap);
    v = base;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0], gap);
      v = v >> 8;
    end
    v = len;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0], gap);
      v = v >> 8;
    end
  endtask

  task automatic send_payload(input logic [31:0] base, input int from, input int to, input bit gap);
    for (int i = from; i < to; i++) begin
      exp_q.push_back({base + 32'(i), pl[i]});
      send_byte(pl[i], gap);
    end
  endtask

  task automatic send_frame(input logic [31:0] base, input int len, input logic [7:0] csum, input bit gap);
    send_hdr(base, 32'(len), gap);
    send_payload(base, 0, len, gap);
    send_byte(csum, gap);
    bus.rx_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", {63'h0, bus.mem_we}, 0);
    check("rst_addr", {32'h0, bus.mem_addr}, 0);
    check("rst_data", {56'h0, bus.mem_data}, 0);
    check("rst_core", {63'h0, core_rst_n}, 0);
    check("rst_busy", {63'h0, busy}, 0);
    check("rst_done", {63'h0, done}, 0);
    check("rst_error", {63'h0, error}, 0);
    check("rst_ready", {63'h0, bus.rx_ready}, 0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", {63'h0, bus.rx_ready}, 1);
  endtask

  initial begin
    int w0;
    logic [7:0] s;
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    @(posedge clk);
    #1;

    // nominal load
    reset_dut();
    pl[0] = 8'h13; pl[1] = 8'h00; pl[2] = 8'h00; pl[3] = 8'h00;
    w0 = writes;
    send_frame(32'h100, 4, 8'h13, 1'b0);
    check("nom_done", {63'h0, done}, 1);
    check("nom_core", {63'h0, core_rst_n}, 1);
    check("nom_error", {63'h0, error}, 0);
    check("nom_ready", {63'h0, bus.rx_ready}, 0);
    check("nom_busy", {63'h0, busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("nom_writes", 64'(writes - w0), 4);

    // bad checksum
    reset_dut();
    w0 = writes;
    send_frame(32'h100, 4, 8'h14, 1'b0);
    check("csum_error", {63'h0, error}, 1);
    check("csum_core", {63'h0, core_rst_n}, 0);
    check("csum_done", {63'h0, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("csum_writes", 64'(writes - w0), 4);

    // out of range, then wrap-around
    reset_dut();
    w0 = writes;
    send_hdr(32'h000F_FFFE, 32'd4, 1'b0);
    bus.rx_valid = 1'b0;
    check("oor_error", {63'h0, error}, 1);
    check("oor_ready", {63'h0, bus.rx_ready}, 0);
    check("oor_core", {63'h0, core_rst_n}, 0);
    reset_dut();
    send_hdr(32'hFFFF_FFFF, 32'd2, 1'b0);
    bus.rx_valid = 1'b0;
    check("wrap_error", {63'h0, error}, 1);
    check("wrap_done", {63'h0, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("oor_writes", 64'(writes - w0), 0);

    // garbage prefix, empty image, stalled stream
    reset_dut();
    w0 = writes;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    check("garbage_busy", {63'h0, busy}, 0);
    send_frame(32'h40, 0, 8'h00, 1'b1);
    check("empty_done", {63'h0, done}, 1);
    check("empty_error", {63'h0, error}, 0);
    check("empty_writes", 64'(writes - w0), 0);

    // reset mid-payload, then a full frame
    reset_dut();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    send_hdr(32'h200, 32'd4, 1'b0);
    send_payload(32'h200, 0, 2, 1'b0);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_we", {63'h0, bus.mem_we}, 0);
    check("mid_addr", {32'h0, bus.mem_addr}, 0);
    check("mid_busy", {63'h0, busy}, 0);
    check("mid_done", {63'h0, done}, 0);
    rst_n = 1'b1;
    #1;
    check("mid_idle_ready", {63'h0, bus.rx_ready}, 1);
    check("mid_scoreboard", 64'(exp_q.size()), 0);
    send_frame(32'h300, 4, 8'hAA, 1'b0);
    check("mid_after_done", {63'h0, done}, 1);

    // throughput: 256 back-to-back payload bytes
    reset_dut();
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      pl[i] = 8'($urandom_range(0, 255));
      s = s + pl[i];
    end
    w0 = writes;
    max_run = 0;
    send_frame(32'h1000, 256, s, 1'b0);
    check("tp_done", {63'h0, done}, 1);
    repeat (2) @(posedge clk);
    #1;
    check("tp_writes", 64'(writes - w0), 256);
    check("tp_run", 64'(max_run), 256);
    check("final_scoreboard", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
